circular_buffer: RTL and testbench
==================================

CIRCULAR_BUFFER -- requirements
Module: circular_buffer

Interface
REQ-001 SHALL provide parameter BUFFER_SIZE, default 8, number of flit entries (integer >= 2; non-power-of-two allowed).
REQ-002 SHALL provide parameter OFF_SLACK, default 2, number of free entries at or below which on_off_o deasserts (1 <= OFF_SLACK < BUFFER_SIZE).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 data_i  input  $bits(flit_novc_t)  flit to enqueue; type flit_novc_t from package noc_params.
REQ-006 read_i  input  1  dequeue request for the current head flit.
REQ-007 write_i  input  1  enqueue request for data_i.
REQ-008 data_o  output  $bits(flit_novc_t)  head flit (oldest stored entry).
REQ-009 is_full_o  output  1  high when occupancy == BUFFER_SIZE.
REQ-010 is_empty_o  output  1  high when occupancy == 0.
REQ-011 on_off_o  output  1  on/off flow-control credit to upstream; 1 = on (may send), 0 = off.

Function
REQ-012 SHALL store flits in a BUFFER_SIZE-entry memory addressed by read and write pointers of width $clog2(BUFFER_SIZE), plus an occupancy counter of width $clog2(BUFFER_SIZE+1).
REQ-013 SHALL drive data_o combinationally from memory[read pointer] (first-word fall-through, zero read latency); the value is valid whenever is_empty_o is low.
REQ-014 Write accepted (write_i and not full, or write_i and read_i while full): memory[write pointer] <= data_i; write pointer advances.
REQ-015 Read accepted (read_i and not empty): read pointer advances; the flit on data_o before the edge is consumed.
REQ-016 Pointers SHALL wrap from BUFFER_SIZE-1 to 0 by explicit compare, independent of power-of-two sizing.
REQ-017 Occupancy: +1 on write only, -1 on read only, unchanged on simultaneous accepted read and write.
REQ-018 Simultaneous read_i and write_i while empty: only the write is accepted; no bypass; data_o shows the new flit the next cycle; is_empty_o goes low.
REQ-019 Simultaneous read_i and write_i while full: both accepted; the buffer remains full.
REQ-020 write_i while full without read_i SHALL be ignored (no state change, no data corruption).
REQ-021 read_i while empty SHALL be ignored (pointers and occupancy unchanged).
REQ-022 is_full_o and is_empty_o SHALL be combinational decodes of the occupancy counter and reflect the new state the cycle after an update.
REQ-023 on_off_o SHALL equal (BUFFER_SIZE - occupancy > OFF_SLACK), decoded combinationally from the occupancy counter.

Reset
REQ-024 While rst is high at a rising edge: pointers = 0, occupancy = 0, all memory entries = 0; read_i and write_i are ignored.
REQ-025 After reset: is_empty_o = 1, is_full_o = 0, on_off_o = 1, data_o = all zeros.
REQ-026 Reset asserted mid-operation SHALL discard all stored flits at that edge, with no partial update.

Configuration
REQ-027 Macro CIRCULAR_BUFFER_ASSERT_EN: when defined, the block SHALL include simulation assertions that report an error on write_i with is_full_o and no read_i, and on read_i with is_empty_o (both outside reset), plus an assertion that is_full_o and is_empty_o are never both high.
REQ-028 When CIRCULAR_BUFFER_ASSERT_EN is undefined, the assertions SHALL be absent; RTL function and ports are identical in both builds.

Verification (BUFFER_SIZE=8, OFF_SLACK=2)
REQ-029 Reset for 5 cycles, then idle -> is_empty_o=1, is_full_o=0, on_off_o=1, data_o=0.
REQ-030 Write flits with payloads 1..3 on consecutive cycles, then read 3 times -> data_o shows 1, 2, 3 in order before each read edge; is_empty_o=1 afterwards.
REQ-031 Write 8 flits -> is_full_o=1 after the 8th; on_off_o=0 from the 6th write onward; a 9th write without read is dropped, and 8 reads return payloads 1..8.
REQ-032 Fill to 8, then simultaneous read+write for 10 cycles -> is_full_o stays 1, output order preserved across pointer wrap.
REQ-033 Simultaneous read+write while empty with payload 0xA -> the next cycle is_empty_o=0 and data_o=0xA; a read on an empty buffer leaves all outputs unchanged.
REQ-034 Assert rst with 4 flits stored -> the next cycle is_empty_o=1, data_o=0; with CIRCULAR_BUFFER_ASSERT_EN defined, an underflow read triggers an error report.

Source files
------------

// File: rtl/circular_buffer.sv
// Flit FIFO with first-word fall-through output and on/off upstream flow control.
// Define CIRCULAR_BUFFER_ASSERT_EN to build in overflow/underflow simulation assertions.

package noc_params;
    typedef logic [1:0] flit_label_t;

    typedef struct packed {
        flit_label_t  flit_label;
        logic [15:0]  payload;
    } flit_novc_t;
endpackage

module circular_buffer
    import noc_params::*;
#(
    parameter int BUFFER_SIZE = 8,
    parameter int OFF_SLACK   = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [$bits(flit_novc_t)-1:0] data_i,
    input  logic                          read_i,
    input  logic                          write_i,
    output logic [$bits(flit_novc_t)-1:0] data_o,
    output logic                          is_full_o,
    output logic                          is_empty_o,
    output logic                          on_off_o
);

    localparam int FLIT_W = $bits(flit_novc_t);
    localparam int PTR_W  = $clog2(BUFFER_SIZE);
    localparam int CNT_W  = $clog2(BUFFER_SIZE + 1);

    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(BUFFER_SIZE - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(BUFFER_SIZE);
    localparam logic [CNT_W-1:0] CNT_SLACK = CNT_W'(OFF_SLACK);

    logic [FLIT_W-1:0] mem_q [BUFFER_SIZE];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  free_slots;
    logic              wr_accept;
    logic              rd_accept;

    assign is_full_o  = (count_q == CNT_FULL);
    assign is_empty_o = (count_q == '0);
    assign free_slots = CNT_FULL - count_q;
    assign on_off_o   = (free_slots > CNT_SLACK);
    assign data_o     = mem_q[rd_ptr_q];

    // A full buffer still takes a write when the head is leaving in the same cycle.
    assign wr_accept = write_i && (!is_full_o || read_i);
    assign rd_accept = read_i && !is_empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (wr_accept) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        if (rd_accept) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end

        unique case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BUFFER_SIZE; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_accept) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

`ifdef CIRCULAR_BUFFER_ASSERT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(write_i && is_full_o && !read_i))
                else $error("circular_buffer: write while full dropped");
            assert (!(read_i && is_empty_o))
                else $error("circular_buffer: read while empty ignored");
        end
        assert (!(is_full_o && is_empty_o))
            else $error("circular_buffer: full and empty both asserted");
    end
`endif

endmodule

// File: tb/tb_circular_buffer.sv
// Directed stimulus for circular_buffer with a queue scoreboard; a monitor pops
// an expected flit whenever the DUT accepts a read.

module tb_circular_buffer;
    import noc_params::*;

    localparam int W = $bits(flit_novc_t);

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] data_i;
    logic         read_i;
    logic         write_i;
    logic [W-1:0] data_o;
    logic         is_full_o;
    logic         is_empty_o;
    logic         on_off_o;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q [$];

    circular_buffer #(.BUFFER_SIZE(8), .OFF_SLACK(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_i     (data_i),
        .read_i     (read_i),
        .write_i    (write_i),
        .data_o     (data_o),
        .is_full_o  (is_full_o),
        .is_empty_o (is_empty_o),
        .on_off_o   (on_off_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock of stimulus; inputs return to idle just after the edge.
    task automatic cyc(input logic w, input logic r, input int d);
        write_i = w;
        read_i  = r;
        data_i  = W'(d);
        @(posedge clk);
        #1;
        write_i = 1'b0;
        read_i  = 1'b0;
        data_i  = '0;
    endtask

    task automatic wr_push(input int d);
        exp_q.push_back(W'(d));
        cyc(1'b1, 1'b0, d);
    endtask

    // Monitor: sampled mid-cycle, a read is accepted whenever the buffer is non-empty.
    always @(negedge clk) begin
        if (!rst && read_i && !is_empty_o) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL read_data: got 0x%0h with no flit expected", data_o);
            end else begin
                chk("read_data", 32'(data_o), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; read_i = 1'b0; write_i = 1'b0; data_i = '0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1'b0, 1'b0, 0);
        chk("reset_empty",  32'(is_empty_o), 1);
        chk("reset_full",   32'(is_full_o),  0);
        chk("reset_on_off", 32'(on_off_o),   1);
        chk("reset_data",   32'(data_o),     0);

        // Read on an empty buffer changes nothing.
        cyc(1'b0, 1'b1, 0);
        chk("underflow_empty",  32'(is_empty_o), 1);
        chk("underflow_full",   32'(is_full_o),  0);
        chk("underflow_on_off", 32'(on_off_o),   1);
        chk("underflow_data",   32'(data_o),     0);

        // Three writes, three reads, in order.
        for (int i = 1; i <= 3; i++) wr_push(i);
        chk("w3_head", 32'(data_o), 1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 0);
        chk("w3_empty_after", 32'(is_empty_o), 1);

        // Fill to capacity; on/off drops once free slots reach 2.
        for (int i = 1; i <= 8; i++) begin
            wr_push(i);
            chk("fill_on_off", 32'(on_off_o), (i >= 6) ? 0 : 1);
            chk("fill_full",   32'(is_full_o), (i == 8) ? 1 : 0);
        end
        cyc(1'b1, 1'b0, 9);
        chk("overflow_full", 32'(is_full_o), 1);
        chk("overflow_head", 32'(data_o), 1);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 0);
        chk("drain_empty",  32'(is_empty_o), 1);
        chk("drain_on_off", 32'(on_off_o), 1);

        // Full with simultaneous read+write across the pointer wrap.
        for (int i = 0; i < 8; i++) wr_push(8'h11 + i);
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(W'(8'h21 + i));
            cyc(1'b1, 1'b1, 8'h21 + i);
            chk("rw_full", 32'(is_full_o), 1);
        end
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 0);
        chk("rw_drain_empty", 32'(is_empty_o), 1);

        // Read+write on empty: only the write lands.
        exp_q.push_back(W'(8'hA));
        cyc(1'b1, 1'b1, 8'hA);
        chk("rw_empty_not_empty", 32'(is_empty_o), 0);
        chk("rw_empty_data",      32'(data_o), 32'hA);
        cyc(1'b0, 1'b1, 0);
        chk("rw_empty_drained", 32'(is_empty_o), 1);

        // Reset mid-operation discards stored flits.
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 8'h31 + i);
        chk("pre_reset_head", 32'(data_o), 32'h31);
        rst = 1'b1;
        cyc(1'b1, 1'b1, 8'h77);
        rst = 1'b0;
        chk("midreset_empty",  32'(is_empty_o), 1);
        chk("midreset_data",   32'(data_o), 0);
        chk("midreset_on_off", 32'(on_off_o), 1);

        wr_push(8'h55);
        cyc(1'b0, 1'b1, 0);
        cyc(1'b0, 1'b0, 0);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
